// File: rtl/alu_issue.sv
// alu_issue: decode/issue and writeback stage sitting in front of the 8-bit ALU.
// Holds the 8x8 register file and the architectural flags. Each instruction
// takes two cycles: it is issued in IDLE and written back at the end of EXEC.
module alu_issue #(
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [15:0] ins_data,
  output logic [4:0]  alu_op,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [2:0]  alu_im,
  input  logic [7:0]  alu_res,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_sf,
  input  logic        alu_of,
  output logic [3:0]  flags,
  output logic [7:0]  show_data,
  output logic        show_valid,
  output logic        done,
  output logic        illegal
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_MOV   = 5'b00110;
  localparam logic [4:0] OP_NOT   = 5'b01000;
  localparam logic [4:0] OP_LDI   = 5'b10000;
  localparam logic [4:0] OP_SHOWR = 5'b11111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic [4:0]  cur_op;
  logic [2:0]  cur_rd;
  logic [7:0]  cur_imm;
  logic [7:0]  regs [8];

  logic [4:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_im;

  assign in_op = ins_data[15:11];
  assign in_rd = ins_data[10:8];
  assign in_rs = ins_data[7:5];
  assign in_im = ins_data[4:2];

  // Ops whose ALU result and flags both land in the architectural state.
  function automatic logic op_writes_flags(input logic [4:0] op);
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7,
      5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: op_writes_flags = 1'b1;
      default:                                 op_writes_flags = 1'b0;
    endcase
  endfunction

  // Ops that actually use the ALU, so operands are presented to it.
  function automatic logic op_drives_alu(input logic [4:0] op);
    op_drives_alu = (op <= 5'd14) || (op == OP_SHOWR);
  endfunction

  // State register; reset always returns to IDLE, aborting any EXEC.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake: ready only in IDLE and never while in reset.
  always_comb begin
    next_state = state;
    ins_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ins_ready = ~reset;
        accept    = ins_valid & ~reset;
        if (accept) next_state = EXEC;
      end
      EXEC: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Issue loads the ALU operand registers; the closing EXEC edge writes back.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_op     <= 5'd0;
      alu_in1    <= 8'd0;
      alu_in2    <= 8'd0;
      alu_im     <= 3'd0;
      flags      <= 4'b0000;
      show_data  <= 8'd0;
      show_valid <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      cur_op     <= OP_NOP;
      cur_rd     <= 3'd0;
      cur_imm    <= 8'd0;
      for (int i = 0; i < 8; i++) regs[i] <= REG_RESET;
    end else begin
      show_valid <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      if (accept) begin
        cur_op  <= in_op;
        cur_rd  <= in_rd;
        cur_imm <= ins_data[7:0];
        if (op_drives_alu(in_op)) begin
          alu_op  <= in_op;
          alu_in1 <= regs[in_rd];
          alu_in2 <= regs[in_rs];
          alu_im  <= in_im;
        end else begin
          alu_op  <= 5'd0;
          alu_in1 <= 8'd0;
          alu_in2 <= 8'd0;
          alu_im  <= 3'd0;
        end
      end else if (state == EXEC) begin
        alu_op  <= 5'd0;
        alu_in1 <= 8'd0;
        alu_in2 <= 8'd0;
        alu_im  <= 3'd0;
        done    <= 1'b1;
        if (op_writes_flags(cur_op)) begin
          regs[cur_rd] <= alu_res;
          flags        <= {alu_cf, alu_zf, alu_sf, alu_of};
        end else if (cur_op == OP_MOV || cur_op == OP_NOT) begin
          regs[cur_rd] <= alu_res;
        end else if (cur_op == OP_LDI) begin
          regs[cur_rd] <= cur_imm;
        end else if (cur_op == OP_SHOWR) begin
          show_data  <= alu_res;
          show_valid <= 1'b1;
        end else if (cur_op != OP_NOP) begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a small behavioural ALU attached.
module tb_alu_issue;

  localparam logic [7:0] RR = 8'h00;

  logic        clock = 1'b0;
  logic        reset;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] ins_data;
  logic [4:0]  alu_op;
  logic [7:0]  alu_in1, alu_in2;
  logic [2:0]  alu_im;
  logic [7:0]  alu_res;
  logic        alu_cf, alu_zf, alu_sf, alu_of;
  logic [3:0]  flags;
  logic [7:0]  show_data;
  logic        show_valid, done, illegal;

  int errors = 0;
  int checks = 0;

  logic [4:0] c_op;
  logic [7:0] c_in1, c_in2;
  logic [2:0] c_im;
  logic       c_ready, c_pulse_exec;
  logic       r_done, r_show, r_ill;
  logic [3:0] r_flags;
  logic [7:0] r_show_data;

  alu_issue #(.REG_RESET(RR)) dut (
    .clock(clock), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_im(alu_im), .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .alu_sf(alu_sf), .alu_of(alu_of), .flags(flags), .show_data(show_data),
    .show_valid(show_valid), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Behavioural ALU covering the opcodes this bench exercises.
  always_comb begin
    logic [8:0] sum;
    sum     = 9'd0;
    alu_res = 8'd0;
    alu_cf  = 1'b0;
    alu_zf  = 1'b0;
    alu_sf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_op)
      5'b00000: {alu_cf, alu_zf, alu_sf, alu_of} = 4'b1111;
      5'b00001: begin
        sum     = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_res = sum[7:0];
        alu_cf  = sum[8];
        alu_zf  = (sum[7:0] == 8'd0);
        alu_sf  = sum[7];
        alu_of  = (alu_in1[7] == alu_in2[7]) && (sum[7] != alu_in1[7]);
      end
      5'b00011: begin
        alu_res = alu_in1 - alu_in2;
        alu_cf  = alu_in1 < alu_in2;
        alu_zf  = (alu_res == 8'd0);
        alu_sf  = alu_res[7];
        alu_of  = (alu_in1[7] != alu_in2[7]) && (alu_res[7] != alu_in1[7]);
      end
      5'b00110: alu_res = alu_in2;
      5'b11111: alu_res = alu_in1;
      default: ;
    endcase
  end

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] im);
    return {op, rd, rs, im, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {5'b10000, rd, imm};
  endfunction

  // Issue one instruction from a negedge, capture EXEC and retire views, end on a negedge.
  task automatic exec_instr(input logic [15:0] w);
    ins_valid = 1'b1;
    ins_data  = w;
    @(posedge clock);
    @(negedge clock);
    c_op = alu_op; c_in1 = alu_in1; c_in2 = alu_in2; c_im = alu_im;
    c_ready = ins_ready;
    c_pulse_exec = done | show_valid | illegal;
    ins_valid = 1'b0;
    ins_data  = ~w;
    @(posedge clock);
    #1;
    r_done = done; r_show = show_valid; r_ill = illegal;
    r_flags = flags; r_show_data = show_data;
    @(negedge clock);
  endtask

  task automatic peek(input logic [2:0] r, output logic [7:0] v);
    exec_instr(enc(5'b00000, r, r, 3'd0));
    v = c_in1;
  endtask

  task automatic test_reset();
    int pulses;
    int bad_alu;
    logic [7:0] v;
    reset = 1'b1; ins_valid = 1'b0; ins_data = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_reset: got %b expected 0", ins_ready); end
    reset = 1'b0;
    pulses = 0; bad_alu = 0;
    repeat (3) begin
      @(negedge clock);
      if (done | show_valid | illegal) pulses++;
      if ({alu_op, alu_in1, alu_in2, alu_im} != 24'd0) bad_alu++;
    end
    checks++;
    if (ins_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", ins_ready); end
    checks++;
    if (pulses != 0 || bad_alu != 0) begin errors++; $display("[TB] FAIL idle_quiet: got pulses=%0d alu_busy=%0d expected 0/0", pulses, bad_alu); end
    checks++;
    if (flags !== 4'b0000 || show_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_flags_show: got %b/%h expected 0000/00", flags, show_data); end
    for (int i = 0; i < 8; i++) begin
      peek(i[2:0], v);
      checks++;
      if (v !== RR) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, v, RR); end
    end
  endtask

  task automatic test_ldi_add();
    logic [7:0] v;
    exec_instr(ldi(3'd1, 8'h7F));
    checks++;
    if ({c_op, c_in1, c_in2, c_im} !== 24'd0) begin errors++; $display("[TB] FAIL ldi_alu_quiet: got op=%b in1=%h in2=%h im=%0d expected all 0", c_op, c_in1, c_in2, c_im); end
    checks++;
    if (r_done !== 1'b1 || r_flags !== 4'b0000) begin errors++; $display("[TB] FAIL ldi_retire: got done=%b flags=%b expected 1/0000", r_done, r_flags); end
    exec_instr(ldi(3'd2, 8'h01));
    exec_instr(enc(5'b00001, 3'd1, 3'd2, 3'd5));
    checks++;
    if (c_op !== 5'b00001 || c_in1 !== 8'h7F || c_in2 !== 8'h01 || c_im !== 3'd5) begin errors++; $display("[TB] FAIL add_operands: got op=%b in1=%h in2=%h im=%0d expected 00001/7f/01/5", c_op, c_in1, c_in2, c_im); end
    checks++;
    if (c_ready !== 1'b0 || c_pulse_exec !== 1'b0) begin errors++; $display("[TB] FAIL exec_state: got ready=%b pulses=%b expected 0/0", c_ready, c_pulse_exec); end
    checks++;
    if (r_done !== 1'b1 || r_flags !== 4'b0011) begin errors++; $display("[TB] FAIL add_retire: got done=%b flags=%b expected 1/0011", r_done, r_flags); end
    peek(3'd1, v);
    checks++;
    if (v !== 8'h80) begin errors++; $display("[TB] FAIL add_r1: got %h expected 80", v); end
  endtask

  task automatic test_mov_nop();
    logic [7:0] v;
    exec_instr(enc(5'b00110, 3'd3, 3'd1, 3'd0));
    checks++;
    if (r_done !== 1'b1 || r_flags !== 4'b0011) begin errors++; $display("[TB] FAIL mov_retire: got done=%b flags=%b expected 1/0011", r_done, r_flags); end
    exec_instr(enc(5'b00000, 3'd0, 3'd0, 3'd0));
    checks++;
    if (r_done !== 1'b1 || r_flags !== 4'b0011) begin errors++; $display("[TB] FAIL nop_retire: got done=%b flags=%b expected 1/0011", r_done, r_flags); end
    peek(3'd3, v);
    checks++;
    if (v !== 8'h80) begin errors++; $display("[TB] FAIL mov_r3: got %h expected 80", v); end
  endtask

  task automatic test_showr();
    logic [7:0] v;
    exec_instr(enc(5'b11111, 3'd1, 3'd0, 3'd0));
    checks++;
    if (c_op !== 5'b11111 || c_in1 !== 8'h80) begin errors++; $display("[TB] FAIL showr_operands: got op=%b in1=%h expected 11111/80", c_op, c_in1); end
    checks++;
    if ({r_show, r_done, r_ill} !== 3'b110 || r_show_data !== 8'h80 || r_flags !== 4'b0011) begin errors++; $display("[TB] FAIL showr_retire: got sv/done/ill=%b%b%b data=%h flags=%b expected 110/80/0011", r_show, r_done, r_ill, r_show_data, r_flags); end
    @(posedge clock);
    #1;
    checks++;
    if (show_valid !== 1'b0 || show_data !== 8'h80) begin errors++; $display("[TB] FAIL showr_pulse_end: got sv=%b data=%h expected 0/80", show_valid, show_data); end
    @(negedge clock);
    peek(3'd1, v);
    checks++;
    if (v !== 8'h80) begin errors++; $display("[TB] FAIL showr_r1: got %h expected 80", v); end
  endtask

  task automatic test_illegal();
    logic [7:0] v;
    exec_instr(enc(5'b10101, 3'd1, 3'd2, 3'd3));
    checks++;
    if ({c_op, c_in1, c_in2, c_im} !== 24'd0) begin errors++; $display("[TB] FAIL illegal_alu_quiet: got op=%b in1=%h in2=%h expected 0", c_op, c_in1, c_in2); end
    checks++;
    if ({r_ill, r_done, r_show} !== 3'b110 || r_flags !== 4'b0011) begin errors++; $display("[TB] FAIL illegal_retire: got ill/done/sv=%b%b%b flags=%b expected 110/0011", r_ill, r_done, r_show, r_flags); end
    peek(3'd1, v);
    checks++;
    if (v !== 8'h80) begin errors++; $display("[TB] FAIL illegal_r1: got %h expected 80", v); end
  endtask

  task automatic test_sub();
    logic [7:0] v;
    exec_instr(enc(5'b00011, 3'd1, 3'd2, 3'd0));
    checks++;
    if (r_done !== 1'b1 || r_flags !== 4'b0001) begin errors++; $display("[TB] FAIL sub_retire: got done=%b flags=%b expected 1/0001", r_done, r_flags); end
    peek(3'd1, v);
    checks++;
    if (v !== 8'h7F) begin errors++; $display("[TB] FAIL sub_r1: got %h expected 7f", v); end
  endtask

  task automatic test_back_to_back();
    int bad;
    int dones;
    logic [7:0] v;
    @(negedge clock);
    ins_valid = 1'b1;
    ins_data  = ldi(3'd4, 8'h11);
    bad = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (ins_ready !== (i % 2 == 0)) bad++;
      if (done) dones++;
      @(negedge clock);
    end
    ins_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL b2b_ready_pattern: got %0d off-pattern cycles expected 0", bad); end
    checks++;
    if (dones != 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", dones); end
    @(negedge clock);
    peek(3'd4, v);
    checks++;
    if (v !== 8'h11) begin errors++; $display("[TB] FAIL b2b_r4: got %h expected 11", v); end
  endtask

  task automatic test_reset_exec();
    logic [7:0] v;
    ins_valid = 1'b1;
    ins_data  = enc(5'b00001, 3'd1, 3'd2, 3'd0);
    @(posedge clock);
    @(negedge clock);
    ins_valid = 1'b0;
    checks++;
    if (ins_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_exec: got ready=%b expected 0", ins_ready); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({done, show_valid, illegal} !== 3'b000 || flags !== 4'b0000 || alu_op !== 5'd0) begin errors++; $display("[TB] FAIL abort_retire: got pulses=%b%b%b flags=%b op=%b expected 000/0000/00000", done, show_valid, illegal, flags, alu_op); end
    @(negedge clock);
    reset = 1'b0;
    peek(3'd1, v);
    checks++;
    if (v !== RR) begin errors++; $display("[TB] FAIL abort_r1: got %h expected %h", v, RR); end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_mov_nop();
    test_showr();
    test_illegal();
    test_sub();
    test_back_to_back();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue and writeback stage directly upstream of the 8-bit ALU. Accepts 16-bit instruction words over a valid/ready handshake and holds the 8×8-bit register file. Drives the ALU's `op`/`in1`/`in2`/`im` inputs from registered outputs, then captures the result and CF/ZF/SF/OF back into the register file and the architectural flag register. Also implements load-immediate and SHOWR display capture.

## Interface
- `REG_RESET`, default 8'h00, reset value of every register-file entry
- `clock`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `ins_valid`  in  1  instruction word present
- `ins_ready`  out  1  stage can accept an instruction this cycle
- `ins_data`  in  16  instruction: [15:11] op, [10:8] rd, [7:5] rs, [4:2] im, [1:0] reserved (ignored); for LDI, [7:0] is imm8
- `alu_op`  out  5  ALU opcode
- `alu_in1`  out  8  R[rd]
- `alu_in2`  out  8  R[rs]
- `alu_im`  out  3  shift/rotate amount
- `alu_res`  in  8  ALU result
- `alu_cf`, `alu_zf`, `alu_sf`, `alu_of`  in  1 each  ALU flags
- `flags`  out  4  architectural {CF,ZF,SF,OF}
- `show_data`  out  8  last SHOWR value
- `show_valid`  out  1  one-cycle pulse when `show_data` updates
- `done`  out  1  one-cycle retire pulse
- `illegal`  out  1  one-cycle pulse, undefined opcode retired

## Operation
- Opcodes:
  - 00000 NOP
  - 00001 ADD
  - 00010 AND
  - 00011 SUB
  - 00100 OR
  - 00101 XOR
  - 00110 MOV
  - 00111 ADC
  - 01000 NOT
  - 01001 SAR
  - 01010 SLR
  - 01011 SAL
  - 01100 SLL
  - 01101 ROL
  - 01110 ROR
  - 10000 LDI
  - 11111 SHOWR
  - All others are undefined.
- FSM has two states, IDLE and EXEC.
  - IDLE: `ins_ready`=1. Handshake (`ins_valid`&`ins_ready`) latches `ins_data`, loads the `alu_*` output registers, and moves to EXEC.
  - EXEC: `ins_ready`=0. At the closing edge, writeback happens and the FSM returns to IDLE.
- ALU outputs in EXEC:
  - `alu_op` = op, `alu_in1` = R[rd], `alu_in2` = R[rs], `alu_im` = im.
  - For LDI and undefined ops, `alu_op` = 00000 and data outputs are 0.
- ALU outputs in IDLE: `alu_op` = 00000, `alu_in1` = `alu_in2` = 0, `alu_im` = 0.
- Writeback at the end of EXEC:
  - ADD, AND, SUB, OR, XOR, ADC, SAR, SLR, SAL, SLL, ROL, ROR: R[rd] ← `alu_res`; `flags` ← {`alu_cf`,`alu_zf`,`alu_sf`,`alu_of`}.
  - MOV, NOT: R[rd] ← `alu_res`; flags unchanged.
  - LDI: R[rd] ← imm8; flags unchanged; ALU ignored.
  - SHOWR: `show_data` ← `alu_res`; `show_valid` pulses; no register or flag write.
  - NOP: no writes. The ALU sets all flags to 1 on NOP; these values are discarded.
  - Undefined ops: no writes; `illegal` pulses.
- `done` pulses for every retired instruction, including NOP and undefined ops.
- rd == rs is legal. R[rd] is read from the registered operand captured at issue.

## Timing
- Reset values:
  - FSM = IDLE.
  - All R[i] = REG_RESET, `flags` = 4'b0000.
  - `alu_*` = 0, `show_data` = 0.
  - `show_valid` = `done` = `illegal` = 0.
  - `ins_ready` = 0 while `reset` is high and 1 in the first cycle after.
- Issue/retire cycle:
  - The handshake at edge T0 makes the `alu_*` outputs valid from T0 through T1. The ALU evaluates during the clock-low phase of that cycle.
  - `alu_res` and the ALU flags are sampled at edge T1; the R/flag write is visible after T1.
  - `done`, `show_valid` and `illegal` are high for the cycle T1..T2.
- Latency is 2 cycles per instruction. With `ins_valid` held high, maximum throughput is one instruction per 2 cycles (accepts at T0, T2, T4…).
- `ins_data` is sampled only on the handshake; changes while `ins_ready`=0 are ignored.
- Reset asserted during EXEC aborts the instruction: no writeback and no `done`. All state takes reset values at that edge.
- Retire and accept never occur on the same edge, because `ins_ready` is 0 in EXEC.

## Test plan
- Reset, then idle 3 cycles → all R = 00, `flags` = 0000, `ins_ready` = 1, `alu_op` = 00000, no pulses.
- LDI R1,0x7F; LDI R2,0x01; ADD R1,R2 against an ALU model → R1 = 0x80, `flags` = 4'b0011 (CF0 ZF0 SF1 OF1), one `done` per instruction 2 cycles apart.
- With `flags` = 0011, MOV R3,R1 then NOP → R3 = 0x80, `flags` stays 0011, two `done` pulses.
- SHOWR R1 with R1 = 0x80 → `show_valid` pulse, `show_data` = 0x80, registers and `flags` unchanged.
- Opcode 10101 → `illegal` and `done` pulse together, `alu_op` = 00000 during EXEC, no state change.
- Issue ADD R1,R2, assert `reset` during EXEC → R1 = REG_RESET, no `done`. With `ins_valid` held high, issues are accepted exactly every 2 cycles.
